// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch/jump redirect,
// data-memory wait states with a timeout watchdog, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegDest,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             Fault,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MEMWAIT = 2'd1;
  localparam logic [1:0] S_FAULT   = 2'd2;

  localparam logic [TO_W-1:0] TIMEOUT = TO_W'(MEM_TIMEOUT);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TO_W-1:0]  r_wait;
  logic [TO_W-1:0]  w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_memstall;
  logic             w_loaduse;
  logic             w_freeze;
  logic             w_fault_out;

  assign w_memstall = MEM_Req & ~MEM_Ready;
  assign w_loaduse  = EX_MemRead & (EX_RegDest != 5'd0) &
                      ((EX_RegDest == ID_rs) | (ID_UsesRt & (EX_RegDest == ID_rt)));

  // Freeze covers both the RUN cycle that first sees the stall and every unready MEMWAIT cycle.
  assign w_freeze    = ((r_state == S_RUN) & w_memstall) | ((r_state == S_MEMWAIT) & ~MEM_Ready);
  assign w_fault_out = (r_state != S_RUN) & (r_state != S_MEMWAIT);

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b1;
    IDEX_Flush   = 1'b0;
    EXMEM_Write  = 1'b1;
    MEMWB_Bubble = 1'b0;
    if (w_fault_out) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      IDEX_Flush   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (w_freeze) begin
      PC_Write     = 1'b0;
      IFID_Write   = 1'b0;
      IDEX_Write   = 1'b0;
      EXMEM_Write  = 1'b0;
      MEMWB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (w_loaduse) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IFID_Flush = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    case (r_state)
      S_RUN: begin
        if (w_memstall) begin
          w_state_nxt = S_MEMWAIT;
          w_wait_nxt  = TO_W'(1);
        end
      end
      S_MEMWAIT: begin
        if (MEM_Ready) begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait >= TIMEOUT) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_nxt = r_wait + TO_W'(1);
        end
      end
      default: w_state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_fault_out && !PC_Write && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (IFID_Flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign Fault      = w_fault_out;
  assign State      = r_state;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + random bench for pipeline_hazard_ctrl against a frozen-streak reference model.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_rs, ID_rt, EX_RegDest;
  logic ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken, MEM_Req, MEM_Ready;

  logic a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_bub, a_fault;
  logic [1:0] a_state;
  logic [15:0] a_stall, a_flush;
  logic b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_bub, b_fault;
  logic [1:0] b_state;
  logic [3:0] b_stall, b_flush;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a fault flag, the length of the current run of frozen cycles, and plain integer counters.
  bit m_fault;
  int m_streak;
  int m_stall_a, m_stall_b, m_flush_a, m_flush_b;
  bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub, e_frozen;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .TO_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(a_pc), .IFID_Write(a_ifw), .IFID_Flush(a_iff), .IDEX_Write(a_idw),
    .IDEX_Flush(a_idf), .EXMEM_Write(a_exw), .MEMWB_Bubble(a_bub), .Fault(a_fault),
    .State(a_state), .StallCount(a_stall), .FlushCount(a_flush)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .TO_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
    .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(b_pc), .IFID_Write(b_ifw), .IFID_Flush(b_iff), .IDEX_Write(b_idw),
    .IDEX_Flush(b_idf), .EXMEM_Write(b_exw), .MEMWB_Bubble(b_bub), .Fault(b_fault),
    .State(b_state), .StallCount(b_stall), .FlushCount(b_flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_streak = 0;
    m_stall_a = 0; m_stall_b = 0; m_flush_a = 0; m_flush_b = 0;
  endtask

  task automatic model_outputs();
    bit lu;
    lu = EX_MemRead && EX_RegDest != 0 &&
         (EX_RegDest == ID_rs || (ID_UsesRt && EX_RegDest == ID_rt));
    e_frozen = !m_fault && !MEM_Ready && (m_streak > 0 || MEM_Req);
    {e_pc, e_ifw, e_idw, e_exw} = 4'b1111;
    {e_iff, e_idf, e_bub} = 3'b000;
    if (m_fault) begin
      {e_pc, e_ifw, e_idw, e_exw} = 4'b0000;
      e_idf = 1; e_bub = 1;
    end else if (e_frozen) begin
      {e_pc, e_ifw, e_idw, e_exw} = 4'b0000;
      e_bub = 1;
    end else if (EX_BranchTaken) begin
      e_iff = 1; e_idf = 1;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_idf = 1;
    end else if (ID_Jump) begin
      e_iff = 1;
    end
  endtask

  task automatic model_edge();
    if (!m_fault && !e_pc) begin
      if (m_stall_a < 65535) m_stall_a++;
      if (m_stall_b < 15) m_stall_b++;
    end
    if (e_iff) begin
      if (m_flush_a < 65535) m_flush_a++;
      if (m_flush_b < 15) m_flush_b++;
    end
    if (!m_fault) begin
      if (e_frozen) begin
        m_streak++;
        if (m_streak == T + 1) m_fault = 1;
      end else begin
        m_streak = 0;
      end
    end
  endtask

  task automatic check_all();
    int es;
    model_outputs();
    es = m_fault ? 2 : (m_streak > 0 ? 1 : 0);
    chk("PC_Write", a_pc, e_pc);
    chk("IFID_Write", a_ifw, e_ifw);
    chk("IFID_Flush", a_iff, e_iff);
    chk("IDEX_Write", a_idw, e_idw);
    chk("IDEX_Flush", a_idf, e_idf);
    chk("EXMEM_Write", a_exw, e_exw);
    chk("MEMWB_Bubble", a_bub, e_bub);
    chk("Fault", a_fault, m_fault);
    chk("State", a_state, es);
    chk("StallCount", a_stall, m_stall_a);
    chk("FlushCount", a_flush, m_flush_a);
    chk("B_PC_Write", b_pc, e_pc);
    chk("B_State", b_state, es);
    chk("B_StallCount", b_stall, m_stall_b);
    chk("B_FlushCount", b_flush, m_flush_b);
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                        input logic jp, input logic mr, input logic [4:0] rd,
                        input logic br, input logic rq, input logic rdy);
    ID_rs = rs; ID_rt = rt; ID_UsesRt = ur; ID_Jump = jp; EX_MemRead = mr;
    EX_RegDest = rd; EX_BranchTaken = br; MEM_Req = rq; MEM_Ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called in the low clock phase; reset is pulsed well clear of any rising edge.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #12;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_State", a_state, 0);
    chk("reset_Fault", a_fault, 0);
    chk("reset_Stall", a_stall, 0);
    chk("reset_Flush", a_flush, 0);
    chk("reset_PC_Write", a_pc, 1);

    // Load-use on rs
    set_in(5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1); step();
    idle(); #1; chk("loaduse_stall_cnt", a_stall, 1);
    step();
    // $0 never stalls; rt only when used
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); #1; chk("r0_nostall", a_pc, 1); step();
    set_in(5'd4, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1); #1; chk("rt_unused_nostall", a_pc, 1); step();
    set_in(5'd4, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1); #1; chk("rt_used_stall", a_pc, 0); step();
    // Branch beats load-use and jump
    pulse_reset();
    set_in(5'd8, 5'd3, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    #1; chk("br_IFID_Flush", a_iff, 1); chk("br_IDEX_Flush", a_idf, 1); chk("br_PC_Write", a_pc, 1);
    step();
    idle(); #1; chk("br_flush_cnt", a_flush, 1);
    step();
    // Memory wait: 3 frozen cycles then ready
    pulse_reset();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    MEM_Ready = 1'b1;
    #1; chk("memwait_unfrozen", a_pc, 1); chk("memwait_state", a_state, 1);
    step();
    idle(); #1; chk("memwait_state_run", a_state, 0); chk("memwait_stall_cnt", a_stall, 3);
    step();
    // Timeout: T+1 frozen cycles then FAULT; ready is ignored afterwards
    pulse_reset();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (T + 1) step();
    #1; chk("timeout_state", a_state, 2); chk("timeout_fault", a_fault, 1);
    MEM_Ready = 1'b1;
    repeat (3) step();
    #1; chk("fault_sticky", a_state, 2); chk("fault_stall_cnt", a_stall, T + 1);
    // Async reset mid-MEMWAIT
    pulse_reset();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    pulse_reset();
    chk("async_state", a_state, 0); chk("async_stall", a_stall, 0); chk("async_fault", a_fault, 0);
    idle(); step();
    // Saturation: 20 stall cycles
    pulse_reset();
    set_in(5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    repeat (20) step();
    #1; chk("sat_stall_b", b_stall, 15); chk("sat_stall_a", a_stall, 20);
    // Random traffic
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 9) < 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB state registers. It detects load-use hazards, branch and jump redirects, and data-memory wait states. It includes a memory-timeout watchdog with a sticky fault state and saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max MEMWAIT cycles before fault (legal range 1..2^TO_W-1)
TO_W, 8, width of wait counter
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ID_rs  input  5  rs field of instruction in ID
ID_rt  input  5  rt field of instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source
ID_Jump  input  1  jump (j/jal/jr) decoded in ID
EX_MemRead  input  1  load in EX
EX_RegDest  input  5  destination register of instruction in EX
EX_BranchTaken  input  1  branch resolved taken in EX
MEM_Req  input  1  MEM stage has MemRead or MemWrite active
MEM_Ready  input  1  data memory completes access this cycle
PC_Write  output  1  PC update enable
IFID_Write  output  1  IF/ID load enable
IFID_Flush  output  1  IF/ID loads NOP
IDEX_Write  output  1  ID/EX load enable
IDEX_Flush  output  1  ID/EX loads bubble (all control fields 0)
EXMEM_Write  output  1  EX/MEM load enable
MEMWB_Bubble  output  1  MEM/WB captures RegWrite=0
Fault  output  1  sticky memory-timeout fault
State  output  2  FSM state: 0 RUN, 1 MEMWAIT, 2 FAULT
StallCount  output  CNT_W  saturating count of cycles with PC_Write=0
FlushCount  output  CNT_W  saturating count of cycles with IFID_Flush=1

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-high. The reset port is named `reset`.
- Reset: State=RUN, WaitCnt=0, Fault=0, StallCount=0, FlushCount=0. Control outputs take their RUN values for the current inputs.
- Control outputs are combinational (Mealy) from State and inputs. Defaults: all *_Write=1, all Flush/Bubble=0.
- Conditions:
  - memstall = MEM_Req & ~MEM_Ready.
  - loaduse = EX_MemRead & (EX_RegDest!=0) & ((EX_RegDest==ID_rs) | (ID_UsesRt & EX_RegDest==ID_rt)).
- Priority in RUN (highest first):
  1. memstall: PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=0, MEMWB_Bubble=1. No flushes. Next state MEMWAIT, WaitCnt<=1.
  2. EX_BranchTaken: IFID_Flush=1, IDEX_Flush=1, PC_Write=1. Overrides loaduse and ID_Jump.
  3. loaduse: PC_Write=0, IFID_Write=0, IDEX_Flush=1. A simultaneous ID_Jump is ignored; the jump is re-evaluated next cycle.
  4. ID_Jump: IFID_Flush=1.
- MEMWAIT:
  - MEM_Ready=1: defaults apply, then priorities 2-4 are evaluated as in RUN. Next state RUN, WaitCnt<=0.
  - MEM_Ready=0: freeze outputs as in priority 1.
    - If WaitCnt>=MEM_TIMEOUT: next state FAULT.
    - Otherwise WaitCnt<=WaitCnt+1.
  - Total frozen cycles before FAULT = MEM_TIMEOUT+1.
- FAULT:
  - PC_Write=IFID_Write=IDEX_Write=EXMEM_Write=0, IDEX_Flush=1, MEMWB_Bubble=1, Fault=1.
  - Exits only on reset. MEM_Ready is ignored.
- Counters:
  - StallCount increments on each clock with PC_Write=0 while State!=FAULT.
  - FlushCount increments on each clock with IFID_Flush=1.
  - Both saturate at all-ones and never wrap.
- Register $0 never causes a load-use stall.
- Reset asserted mid-MEMWAIT or in FAULT returns to RUN immediately (asynchronous). Counters clear.

Test Plan:
- Load-use: EX_MemRead=1, EX_RegDest=8, ID_rs=8 for 1 cycle -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 that cycle. StallCount=1 after the edge.
- $0 and rt masking:
  - EX_RegDest=0 matching ID_rs=0 -> no stall.
  - EX_RegDest=9, ID_rt=9, ID_UsesRt=0 -> no stall.
  - Same with ID_UsesRt=1 -> stall.
- Branch vs load-use vs jump in the same cycle: EX_BranchTaken=1, loaduse true, ID_Jump=1 -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1. FlushCount +1.
- Memory wait: MEM_Req=1 with MEM_Ready low for 3 cycles, then high -> 3 frozen cycles (State RUN, MEMWAIT, MEMWAIT). Fourth cycle unfrozen, State back to RUN. StallCount=3.
- Timeout with MEM_TIMEOUT=4: MEM_Ready held 0 -> 5 frozen cycles, then State=FAULT, Fault=1. Later MEM_Ready=1 has no effect. StallCount stays 5.
- Async reset mid-MEMWAIT: reset pulsed between clock edges -> State=0, counters 0, Fault=0 before the next edge.
- Saturation with CNT_W=4: force 20 stall cycles -> StallCount=15.
